// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: writes every pixel of a clipped rectangle into the 512x256 1-bit framebuffer.
// Latency: SETUP one cycle after acceptance; first write decided on that edge; done one cycle after the last write.
// Backpressure: writes are issued only while blanking is high; the cursor stalls (no loss, no repeat) otherwise.
//
// Ports: clk, reset (sync, active-high), start_fill/fill_value/X1/Y1/X2/Y2 (command), blanking (write permit),
//        busy/done (status), ram_x/ram_y/ram_we/ram_wdata (registered framebuffer write port).
module rect_fill_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_fill,
  input  logic        fill_value,
  input  logic [15:0] X1,
  input  logic [15:0] Y1,
  input  logic [15:0] X2,
  input  logic [15:0] Y2,
  input  logic        blanking,
  output logic        busy,
  output logic        done,
  output logic [8:0]  ram_x,
  output logic [7:0]  ram_y,
  output logic        ram_we,
  output logic        ram_wdata
);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  state_t      state;
  logic [15:0] cx1, cy1, cx2, cy2;
  logic        val;
  logic [8:0]  xmin_r, xmax_r, cur_x;
  logic [7:0]  ymax_r, cur_y;
  logic        pending;    // cursor points at a pixel that still has to be written

  // Normalised and clipped bounds, derived from the captured corners during SETUP.
  logic [15:0] xmin16, xmax16, ymin16, ymax16;
  logic        off_screen, single;
  logic [8:0]  xmin_c, xmax_c;
  logic [7:0]  ymin_c, ymax_c;
  logic        at_xmax, last;

  always_comb begin
    xmin16     = (cx1 < cx2) ? cx1 : cx2;
    xmax16     = (cx1 < cx2) ? cx2 : cx1;
    ymin16     = (cy1 < cy2) ? cy1 : cy2;
    ymax16     = (cy1 < cy2) ? cy2 : cy1;
    off_screen = (xmin16 > 16'd511) || (ymin16 > 16'd255);
    xmin_c     = xmin16[8:0];
    ymin_c     = ymin16[7:0];
    xmax_c     = (xmax16 > 16'd511) ? 9'd511 : xmax16[8:0];
    ymax_c     = (ymax16 > 16'd255) ? 8'd255 : ymax16[7:0];
    single     = (xmin_c == xmax_c) && (ymin_c == ymax_c);
    at_xmax    = (cur_x == xmax_r);
    last       = at_xmax && (cur_y == ymax_r);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_we    <= 1'b0;
      ram_x     <= 9'd0;
      ram_y     <= 8'd0;
      ram_wdata <= 1'b0;
      cx1       <= 16'd0;
      cy1       <= 16'd0;
      cx2       <= 16'd0;
      cy2       <= 16'd0;
      val       <= 1'b0;
      xmin_r    <= 9'd0;
      xmax_r    <= 9'd0;
      ymax_r    <= 8'd0;
      cur_x     <= 9'd0;
      cur_y     <= 8'd0;
      pending   <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_fill) begin
            cx1   <= X1;
            cy1   <= Y1;
            cx2   <= X2;
            cy2   <= Y2;
            val   <= fill_value;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (off_screen) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            xmin_r <= xmin_c;
            xmax_r <= xmax_c;
            ymax_r <= ymax_c;
            state  <= FILL;
            // The first pixel can already be issued on this edge, so the
            // first write lands in the cycle after SETUP.
            if (blanking) begin
              ram_we    <= 1'b1;
              ram_x     <= xmin_c;
              ram_y     <= ymin_c;
              ram_wdata <= val;
              pending   <= !single;
              if (xmin_c != xmax_c) begin
                cur_x <= xmin_c + 9'd1;
                cur_y <= ymin_c;
              end else begin
                cur_x <= xmin_c;
                cur_y <= ymin_c + 8'd1;
              end
            end else begin
              cur_x   <= xmin_c;
              cur_y   <= ymin_c;
              pending <= 1'b1;
            end
          end
        end
        FILL: begin
          // One extra FILL cycle after the last write keeps done one cycle
          // behind the final ram_we.
          if (!pending) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (blanking) begin
            ram_we    <= 1'b1;
            ram_x     <= cur_x;
            ram_y     <= cur_y;
            ram_wdata <= val;
            if (last) begin
              pending <= 1'b0;
            end else if (at_xmax) begin
              cur_x <= xmin_r;
              cur_y <= cur_y + 8'd1;
            end else begin
              cur_x <= cur_x + 9'd1;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Scoreboard bench for rect_fill_engine: a reference model expands each command into its
// expected pixel list; a monitor pops and compares on every ram_we and checks done alignment.
module tb_rect_fill_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_fill = 1'b0;
  logic        fill_value = 1'b0;
  logic [15:0] X1 = 16'd0, Y1 = 16'd0, X2 = 16'd0, Y2 = 16'd0;
  logic        blanking = 1'b1;
  logic        busy, done, ram_we, ram_wdata;
  logic [8:0]  ram_x;
  logic [7:0]  ram_y;

  always #5 clk = ~clk;

  rect_fill_engine dut (
    .clk(clk), .reset(reset), .start_fill(start_fill), .fill_value(fill_value),
    .X1(X1), .Y1(Y1), .X2(X2), .Y2(Y2), .blanking(blanking),
    .busy(busy), .done(done), .ram_x(ram_x), .ram_y(ram_y),
    .ram_we(ram_we), .ram_wdata(ram_wdata)
  );

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic       v;
  } wr_t;

  wr_t  exp_q[$];
  logic blank_pat[$];
  int   tests = 0, fails = 0;
  int   cyc = 0;
  int   done_seen = 0, done_exp = 0, writes_seen = 0;
  int   blank_mode = 0;
  logic blank_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    blank_q <= blanking;
  end

  // Blanking driver: explicit pattern first, else constant-high or random.
  always @(posedge clk) begin
    #2;
    if (blank_pat.size() > 0) blanking = blank_pat.pop_front();
    else if (blank_mode == 0) blanking = 1'b1;
    else blanking = ($urandom_range(0, 3) != 0);
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_we) begin
        wr_t e;
        writes_seen++;
        chk("write_outside_blanking", 32'(blank_q), 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("wr_x", 32'(ram_x), 32'(e.x));
          chk("wr_y", 32'(ram_y), 32'(e.y));
          chk("wr_data", 32'(ram_wdata), 32'(e.v));
        end
      end
      if (done) begin
        done_seen++;
        chk("done_with_writes_pending", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  // Reference model: normalise, reject off-screen, clamp, expand row-major.
  task automatic model(input int x1, input int y1, input int x2, input int y2,
                       input logic v, output int n);
    int xlo, xhi, ylo, yhi;
    wr_t e;
    xlo = (x1 < x2) ? x1 : x2;
    xhi = (x1 < x2) ? x2 : x1;
    ylo = (y1 < y2) ? y1 : y2;
    yhi = (y1 < y2) ? y2 : y1;
    n = 0;
    if (xlo > 511 || ylo > 255) return;
    if (xhi > 511) xhi = 511;
    if (yhi > 255) yhi = 255;
    for (int yy = ylo; yy <= yhi; yy++) begin
      for (int xx = xlo; xx <= xhi; xx++) begin
        e.x = 9'(xx);
        e.y = 8'(yy);
        e.v = v;
        exp_q.push_back(e);
        n++;
      end
    end
  endtask

  // Call at #1 after a posedge with the DUT idle at the next edge.
  task automatic issue(input int x1, input int y1, input int x2, input int y2,
                       input logic v, output int n, output int acc);
    model(x1, y1, x2, y2, v, n);
    X1 = 16'(x1); Y1 = 16'(y1); X2 = 16'(x2); Y2 = 16'(y2);
    fill_value = v;
    start_fill = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    start_fill = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int limit, output int dcyc);
    int d0;
    d0 = done_seen;
    dcyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (done_seen != d0) begin
        dcyc = cyc;
        break;
      end
    end
    done_exp++;
    if (dcyc < 0) chk("done_timeout", 32'(done_seen - d0), 32'd1);
    @(posedge clk); #1;
    chk("busy_low_after_done", 32'(busy), 32'd0);
    chk("done_single_pulse", 32'(done), 32'd0);
  endtask

  // lat: -1 skip latency check, 0 expect writes+1 (constant blanking), >0 explicit.
  task automatic cmd(input int x1, input int y1, input int x2, input int y2,
                     input logic v, input int lat);
    int n, acc, dcyc, w0;
    w0 = writes_seen;
    issue(x1, y1, x2, y2, v, n, acc);
    wait_done((n + 4) * 8 + 50, dcyc);
    chk("write_count", 32'(writes_seen - w0), 32'(n));
    if (lat == 0) chk("done_latency", 32'(dcyc - acc), 32'(n + 1));
    else if (lat > 0) chk("done_latency", 32'(dcyc - acc), 32'(lat));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, acc, dcyc, w0, m, x1, x2, y1, y2, d;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_x", 32'(ram_x), 32'd0);
    chk("rst_y", 32'(ram_y), 32'd0);
    chk("rst_wdata", 32'(ram_wdata), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic 2x2, with first-write timing.
    w0 = writes_seen;
    issue(10, 20, 11, 21, 1'b1, n, acc);
    @(posedge clk); #1;
    chk("first_we", 32'(ram_we), 32'd1);
    chk("first_x", 32'(ram_x), 32'd10);
    chk("first_y", 32'(ram_y), 32'd20);
    wait_done(60, dcyc);
    chk("basic_done_cycle", 32'(dcyc - acc), 32'd5);
    chk("basic_writes", 32'(writes_seen - w0), 32'd4);

    cmd(5, 3, 2, 1, 1'b0, 0);            // swapped corners, 12 writes
    cmd(510, 255, 600, 300, 1'b1, 0);    // clipped to 2 writes
    cmd(700, 10, 700, 20, 1'b1, 1);      // fully off-screen
    cmd(100, 100, 100, 100, 1'b1, 2);    // single pixel
    cmd(0, 0, 0, 0, 1'b0, 0);            // origin corner
    cmd(511, 255, 511, 255, 1'b1, 0);    // far corner, no cursor wrap

    // Blanking gating: 1x3 fill with blanking 1,0,0,1,1 from the SETUP edge.
    blank_pat.push_back(1'b1);
    blank_pat.push_back(1'b1);
    blank_pat.push_back(1'b0);
    blank_pat.push_back(1'b0);
    blank_pat.push_back(1'b1);
    blank_pat.push_back(1'b1);
    cmd(30, 40, 32, 40, 1'b1, 6);

    // Busy rejection: a second strobe during FILL must be ignored.
    w0 = writes_seen;
    issue(50, 60, 57, 62, 1'b1, n, acc);
    repeat (4) @(posedge clk);
    #1;
    X1 = 16'd0; Y1 = 16'd0; X2 = 16'd3; Y2 = 16'd3; fill_value = 1'b0;
    start_fill = 1'b1;
    @(posedge clk); #1;
    start_fill = 1'b0;
    wait_done(200, dcyc);
    chk("reject_latency", 32'(dcyc - acc), 32'(n + 1));
    chk("reject_writes", 32'(writes_seen - w0), 32'(n));
    repeat (5) @(posedge clk);
    #1;
    chk("reject_no_second_cmd", 32'(busy), 32'd0);
    chk("reject_done_count", 32'(done_seen), 32'(done_exp));

    // Randomized commands with random blanking.
    blank_mode = 1;
    for (int k = 0; k < 30; k++) begin
      m = $urandom_range(0, 9);
      if (m < 7) begin
        x1 = $urandom_range(0, 515);
        d  = $urandom_range(0, 6);
        x2 = ($urandom_range(0, 1) == 1) ? x1 + d : ((x1 >= d) ? x1 - d : 0);
        y1 = $urandom_range(0, 260);
        d  = $urandom_range(0, 5);
        y2 = ($urandom_range(0, 1) == 1) ? y1 + d : ((y1 >= d) ? y1 - d : 0);
      end else if (m < 9) begin
        x1 = $urandom_range(505, 511);
        x2 = 16'hFFF0 + $urandom_range(0, 15);
        y1 = 16'hFF00;
        y2 = $urandom_range(250, 255);
      end else begin
        x1 = $urandom_range(512, 65535);
        x2 = $urandom_range(512, 65535);
        y1 = $urandom_range(0, 65535);
        y2 = $urandom_range(0, 65535);
      end
      cmd(x1, y1, x2, y2, 1'($urandom_range(0, 1)), -1);
    end
    blank_mode = 0;

    // Reset mid-fill after 5 of 20 writes.
    w0 = writes_seen;
    issue(200, 100, 204, 103, 1'b1, n, acc);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (writes_seen - w0 >= 5) break;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_we", 32'(ram_we), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_writes", 32'(writes_seen - w0), 32'd5);
    exp_q.delete();
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done_seen), 32'(done_exp));
    cmd(7, 9, 7, 9, 1'b1, 2);

    chk("final_done_count", 32'(done_seen), 32'(done_exp));
    chk("final_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
    $finish;
  end

endmodule
